// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo read-side stream adapter.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH  = 8;
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // Number of bits needed to represent 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Circular word store behind the FIFO read port, with a separate occupancy count
// so that a full buffer and an empty buffer can never be confused.
module skid_buffer
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int  DEPTH      = 3,
    localparam int PTR_W      = clog2(DEPTH),
    localparam int OCC_W      = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is cleared on reset so the head word reads as zero until refilled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops sync_fifo words and presents them as a bubble-free valid/ready stream;
// read issue depends only on registered state, never on m_ready.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = FIFO_DATA_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  idle
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int OCC_W     = clog2(BUF_DEPTH + 1);
    localparam int LVL_W     = clog2(BUF_DEPTH + READ_LATENCY + 1);

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("fifo_stream_reader: READ_LATENCY must be 1 or 2");
    end

    logic [READ_LATENCY-1:0] pipe;
    logic [READ_LATENCY-1:0] pipe_nxt;
    logic [OCC_W-1:0]        occ;
    logic [OCC_W-1:0]        occ_nxt;
    logic [LVL_W-1:0]        inflight;
    logic [LVL_W-1:0]        level;
    logic                    run;
    logic                    capture;
    logic                    pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + LVL_W'(pipe[i]);
    end

    assign level = LVL_W'(occ) + inflight;

    // run is cleared by reset, which keeps the strobe low while reset is held.
    assign fifo_rd_en = run & en & ~fifo_empty & (level < LVL_W'(BUF_DEPTH));
    assign capture    = pipe[READ_LATENCY-1];
    assign m_valid    = (occ != '0);
    assign pop        = m_valid & m_ready;
    assign pipe_nxt   = READ_LATENCY'({pipe, fifo_rd_en});
    assign occ_nxt    = occ + OCC_W'(capture) - OCC_W'(pop);

    skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run      <= 1'b0;
            pipe     <= '0;
            word_cnt <= '0;
            idle     <= 1'b1;
        end else begin
            run  <= 1'b1;
            pipe <= pipe_nxt;
            if (pop) word_cnt <= word_cnt + 1'b1;
            idle <= ~en & (occ_nxt == '0) & (pipe_nxt == '0);
        end
    end

    a_no_capture_full: assert property (@(posedge clk) disable iff (!reset)
        capture |-> (occ != OCC_W'(BUF_DEPTH)));

    a_no_read_empty: assert property (@(posedge clk) disable iff (!reset)
        fifo_rd_en |-> !fifo_empty);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: lane 0 at READ_LATENCY=1, lane 1 at READ_LATENCY=2,
// each fed by a queue-based sync_fifo stand-in and checked against its pop order.
module tb_fifo_stream_reader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_lane
        logic        en         = 1'b0;
        logic        m_ready    = 1'b0;
        logic        fifo_empty = 1'b1;
        logic [7:0]  fifo_dout  = '0;
        logic [7:0]  dout_s1    = '0;
        logic        fifo_rd_en;
        logic        m_valid;
        logic        idle;
        logic [7:0]  m_data;
        logic [15:0] word_cnt;
        logic [7:0]  wq[$];
        logic [7:0]  fq[$];
        logic [7:0]  exp_q[$];
        int          strobes   = 0;
        int          accepted  = 0;
        logic        hold_prev = 1'b0;
        logic [7:0]  prev_data = '0;

        fifo_stream_reader #(
            .DATA_WIDTH   (8),
            .READ_LATENCY (g + 1),
            .CNT_WIDTH    (16)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .fifo_rd_en (fifo_rd_en),
            .fifo_dout  (fifo_dout),
            .fifo_empty (fifo_empty),
            .m_valid    (m_valid),
            .m_ready    (m_ready),
            .m_data     (m_data),
            .word_cnt   (word_cnt),
            .idle       (idle)
        );

        // sync_fifo stand-in: writes land at the edge, empty is registered,
        // dout is valid READ_LATENCY cycles after the strobe.
        always @(posedge clk) begin
            logic [7:0] w;
            w = (g == 0) ? fifo_dout : dout_s1;
            if (fifo_rd_en) begin
                strobes++;
                if (fq.size() > 0) begin
                    w = fq.pop_front();
                    exp_q.push_back(w);
                end
            end
            while (wq.size() > 0) fq.push_back(wq.pop_front());
            fifo_empty <= (fq.size() == 0);
            if (g == 0) fifo_dout <= w;
            else begin
                dout_s1   <= w;
                fifo_dout <= dout_s1;
            end
        end

        // Words read but not delivered before a reset are lost by definition.
        always @(negedge reset) begin
            exp_q.delete();
            accepted  = 0;
            hold_prev = 1'b0;
        end

        always @(negedge clk) begin
            if (reset) begin
                if (fifo_rd_en) chk("rd_while_empty", fifo_empty, 1'b0);
                if (hold_prev) begin
                    chk("hold_valid", m_valid, 1'b1);
                    chk("hold_data", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    chk("word_cnt", word_cnt, 16'(accepted));
                    if (exp_q.size() > 0) chk("data", m_data, exp_q.pop_front());
                    else chk("spurious_valid", m_valid, 1'b0);
                    accepted++;
                end
                hold_prev = m_valid & ~m_ready;
                prev_data = m_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rd_bits;
        logic [7:0]  v_bits;
        logic [7:0]  dat [8];
        logic [11:0] v12;
        logic [19:0] vb;
        logic        rd_or;
        logic        v_or;
        logic [7:0]  got;
        int          s0;
        int          a0;

        // reset values
        #1 reset = 1'b0;
        #2;
        chk("rst_rd_en", gen_lane[0].fifo_rd_en, 1'b0);
        chk("rst_valid", gen_lane[0].m_valid, 1'b0);
        chk("rst_data", gen_lane[0].m_data, 8'h00);
        chk("rst_cnt", gen_lane[0].word_cnt, 16'h0000);
        chk("rst_idle", gen_lane[0].idle, 1'b1);
        chk("rst_idle_l1", gen_lane[1].idle, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // back-to-back stream C4 C4 FF
        gen_lane[0].wq.push_back(8'hC4);
        gen_lane[0].wq.push_back(8'hC4);
        gen_lane[0].wq.push_back(8'hFF);
        tick();
        tick();
        gen_lane[0].en      = 1'b1;
        gen_lane[0].m_ready = 1'b1;
        rd_bits = '0;
        v_bits  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_bits[i] = gen_lane[0].fifo_rd_en;
            v_bits[i]  = gen_lane[0].m_valid;
            dat[i]     = gen_lane[0].m_data;
        end
        chk("t1_strobes", rd_bits, 8'b0000_0111);
        chk("t1_valid", v_bits, 8'b0001_1100);
        chk("t1_d0", dat[2], 8'hC4);
        chk("t1_d1", dat[3], 8'hC4);
        chk("t1_d2", dat[4], 8'hFF);
        chk("t1_cnt", gen_lane[0].word_cnt, 16'd3);
        tick();
        chk("t1_idle_busy", gen_lane[0].idle, 1'b0);
        gen_lane[0].en = 1'b0;
        tick();
        tick();
        chk("t1_idle", gen_lane[0].idle, 1'b1);

        // back-pressure with 00..09
        for (int i = 0; i < 10; i++) gen_lane[0].wq.push_back(8'(i));
        tick();
        tick();
        s0 = gen_lane[0].strobes;
        gen_lane[0].en      = 1'b1;
        gen_lane[0].m_ready = 1'b0;
        repeat (8) tick();
        chk("t2_strobes", gen_lane[0].strobes - s0, 3);
        chk("t2_valid", gen_lane[0].m_valid, 1'b1);
        chk("t2_data", gen_lane[0].m_data, 8'h00);
        a0 = gen_lane[0].accepted;
        gen_lane[0].m_ready = 1'b1;
        v12 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            v12[i] = gen_lane[0].m_valid;
        end
        chk("t2_stream", v12, 12'h3FF);
        chk("t2_accepted", gen_lane[0].accepted - a0, 10);
        tick();
        gen_lane[0].en = 1'b0;

        // empty boundary then a single A5
        tick();
        gen_lane[0].en = 1'b1;
        rd_or = 1'b0;
        v_or  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_or |= gen_lane[0].fifo_rd_en;
            v_or  |= gen_lane[0].m_valid;
        end
        chk("t3_no_strobe", rd_or, 1'b0);
        chk("t3_no_valid", v_or, 1'b0);
        s0  = gen_lane[0].strobes;
        a0  = gen_lane[0].accepted;
        got = '0;
        gen_lane[0].wq.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gen_lane[0].m_valid) got = gen_lane[0].m_data;
        end
        chk("t3_one_strobe", gen_lane[0].strobes - s0, 1);
        chk("t3_data", got, 8'hA5);
        chk("t3_accepted", gen_lane[0].accepted - a0, 1);

        // disable after the second strobe
        tick();
        gen_lane[0].en = 1'b0;
        for (int i = 0; i < 8; i++) gen_lane[0].wq.push_back(8'($urandom_range(0, 255)));
        tick();
        tick();
        s0 = gen_lane[0].strobes;
        a0 = gen_lane[0].accepted;
        gen_lane[0].en = 1'b1;
        tick();
        tick();
        gen_lane[0].en = 1'b0;
        repeat (8) tick();
        chk("t4_strobes", gen_lane[0].strobes - s0, 2);
        chk("t4_delivered", gen_lane[0].accepted - a0, 2);
        chk("t4_idle", gen_lane[0].idle, 1'b1);
        chk("t4_fifo_left", gen_lane[0].fq.size(), 6);

        // async reset with occ=2 and one read in flight
        gen_lane[0].m_ready = 1'b0;
        tick();
        s0 = gen_lane[0].strobes;
        gen_lane[0].en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gen_lane[0].strobes - s0 >= 3) break;
        end
        chk("t5_three_strobes", gen_lane[0].strobes - s0, 3);
        chk("t5_pre_valid", gen_lane[0].m_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rd_en", gen_lane[0].fifo_rd_en, 1'b0);
        chk("t5_valid", gen_lane[0].m_valid, 1'b0);
        chk("t5_data", gen_lane[0].m_data, 8'h00);
        chk("t5_cnt", gen_lane[0].word_cnt, 16'h0000);
        chk("t5_idle", gen_lane[0].idle, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        gen_lane[0].m_ready = 1'b1;
        repeat (12) tick();
        chk("t5_after_cnt", gen_lane[0].word_cnt, 16'd3);
        chk("t5_fifo_drained", gen_lane[0].fq.size(), 0);
        gen_lane[0].en = 1'b0;
        tick();

        // READ_LATENCY=2, 256 words, full rate then random m_ready
        for (int i = 0; i < 256; i++) gen_lane[1].wq.push_back(8'($urandom_range(0, 255)));
        tick();
        tick();
        gen_lane[1].en      = 1'b1;
        gen_lane[1].m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vb[i] = gen_lane[1].m_valid;
        end
        chk("t6_latency", vb[3:0], 4'b1000);
        chk("t6_rate", vb[19:3], 17'h1FFFF);
        for (int c = 0; c < 3000 && gen_lane[1].accepted < 256; c++) begin
            tick();
            gen_lane[1].m_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        gen_lane[1].m_ready = 1'b0;
        gen_lane[1].en      = 1'b0;
        tick();
        chk("t6_accepted", gen_lane[1].accepted, 256);
        chk("t6_word_cnt", gen_lane[1].word_cnt, 16'd256);
        chk("t6_fifo_drained", gen_lane[1].fq.size(), 0);
        tick();
        chk("t6_idle", gen_lane[1].idle, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
